execute_stage: RTL and testbench

- EX stage of the multicycle MIPS datapath, directly upstream of the data memory.
- When the stage counter reads 2 (EX), it captures the decoded operands and computes the ALU result.
- It drives memaddress, invalue, memRead and memWrite, which stay stable through stage 3 (MEM) for the memory to sample.
- An optional iterative multiplier stretches EX by asserting a stall that holds the stage sequencer.

---
 rtl/execute_stage_if.sv | 34 +++
 rtl/execute_stage.sv | 193 +++++++++++++++++++
 tb/tb_execute_stage.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/execute_stage_if.sv
// Operand/control bundle between the decode/sequencer side and the EX stage.
// The master drives decoded operands; the slave returns results and stall.
interface execute_stage_if;
  logic [2:0]  stage;
  logic [3:0]  aluop;
  logic [31:0] operandA;
  logic [31:0] operandB;
  logic [15:0] immediate;
  logic        aluSrc;
  logic        memRead_in;
  logic        memWrite_in;
  logic [31:0] aluresult;
  logic        zero;
  logic [7:0]  memaddress;
  logic [31:0] invalue;
  logic        memRead;
  logic        memWrite;
  logic        stall;
  logic        done;

  modport master (
    output stage, aluop, operandA, operandB,
    output immediate, aluSrc, memRead_in, memWrite_in,
    input  aluresult, zero, memaddress, invalue,
    input  memRead, memWrite, stall, done
  );

  modport slave (
    input  stage, aluop, operandA, operandB,
    input  immediate, aluSrc, memRead_in, memWrite_in,
    output aluresult, zero, memaddress, invalue,
    output memRead, memWrite, stall, done
  );
endinterface

// File: rtl/execute_stage.sv
// EX stage of the multicycle MIPS datapath; drives the data memory port.
// Define EXEC_MULT_EN to build the iterative shift-add MUL and its stall.
module execute_stage #(
  parameter logic [2:0] EX_STAGE   = 3'd2,
  parameter int         MUL_CYCLES = 32
) (
  input logic clock,
  input logic reset,
  execute_stage_if.slave bus
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;
`ifdef EXEC_MULT_EN
  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam int CW = $clog2(MUL_CYCLES + 1);
`endif

`ifdef EXEC_MULT_EN
  typedef enum logic [1:0] {IDLE, MUL, WAIT} state_t;
`else
  typedef enum logic [1:0] {IDLE, WAIT} state_t;
`endif

  state_t state;
  state_t state_n;

  logic        ex_hit;
  logic        is_mul;
  logic        cap;
  logic [31:0] b_sel;
  logic [31:0] alu_val;

  logic [31:0] res_q;
  logic        zero_q;
  logic [31:0] inval_q;
  logic        mr_q;
  logic        mw_q;
  logic        done_q;

  logic is_and, is_or, is_add;
  logic is_sub, is_slt, is_nor;

`ifdef EXEC_MULT_EN
  logic [31:0] mcand;
  logic [31:0] mplier;
  logic [31:0] acc;
  logic [31:0] acc_n;
  logic [CW-1:0] cnt;
  logic        last;
`endif

  assign ex_hit = (bus.stage == EX_STAGE);

  assign b_sel = bus.aluSrc
               ? {{16{bus.immediate[15]}}, bus.immediate}
               : bus.operandB;

  assign is_and = (bus.aluop == OP_AND);
  assign is_or  = (bus.aluop == OP_OR);
  assign is_add = (bus.aluop == OP_ADD);
  assign is_sub = (bus.aluop == OP_SUB);
  assign is_slt = (bus.aluop == OP_SLT);
  assign is_nor = (bus.aluop == OP_NOR);

`ifdef EXEC_MULT_EN
  assign is_mul = (bus.aluop == OP_MUL);
`else
  assign is_mul = 1'b0;
`endif

  // Single-cycle ALU; MUL and unknown codes fall through to zero here.
  always_comb begin
    alu_val = 32'd0;
    unique case (1'b1)
      is_and: alu_val = bus.operandA & b_sel;
      is_or:  alu_val = bus.operandA | b_sel;
      is_add: alu_val = bus.operandA + b_sel;
      is_sub: alu_val = bus.operandA - b_sel;
      is_slt: alu_val = {31'd0,
                $signed(bus.operandA) < $signed(b_sel)};
      is_nor: alu_val = ~(bus.operandA | b_sel);
      default: alu_val = 32'd0;
    endcase
  end

`ifdef EXEC_MULT_EN
  assign acc_n = mplier[0] ? acc + mcand : acc;
  assign last  = (cnt == CW'(MUL_CYCLES - 1));
`endif

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    cap     = 1'b0;
    case (state)
      IDLE: begin
        if (ex_hit) begin
          cap     = 1'b1;
`ifdef EXEC_MULT_EN
          state_n = is_mul ? MUL : WAIT;
`else
          state_n = WAIT;
`endif
        end
      end
`ifdef EXEC_MULT_EN
      MUL: begin
        if (last) state_n = WAIT;
      end
`endif
      WAIT: begin
        if (!ex_hit) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      res_q   <= 32'd0;
      zero_q  <= 1'b0;
      inval_q <= 32'd0;
      mr_q    <= 1'b0;
      mw_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (cap) begin
        inval_q <= bus.operandB;
        mr_q    <= bus.memRead_in;
        mw_q    <= bus.memWrite_in;
        if (!is_mul) begin
          res_q  <= alu_val;
          zero_q <= (alu_val == 32'd0);
          done_q <= 1'b1;
        end
      end
`ifdef EXEC_MULT_EN
      if (state == MUL && last) begin
        res_q  <= acc_n;
        zero_q <= (acc_n == 32'd0);
        done_q <= 1'b1;
      end
`endif
    end
  end

`ifdef EXEC_MULT_EN
  // Reset clears the partial product so an aborted MUL leaves no trace.
  always_ff @(posedge clock) begin
    if (reset) begin
      mcand  <= 32'd0;
      mplier <= 32'd0;
      acc    <= 32'd0;
      cnt    <= '0;
    end else if (cap && is_mul) begin
      mcand  <= bus.operandA;
      mplier <= b_sel;
      acc    <= 32'd0;
      cnt    <= '0;
    end else if (state == MUL) begin
      acc    <= acc_n;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
    end
  end

  assign bus.stall = !reset &&
    ((state == IDLE && ex_hit && is_mul) ||
     state == MUL);
`else
  assign bus.stall = 1'b0;
`endif

  assign bus.aluresult  = res_q;
  assign bus.zero       = zero_q;
  assign bus.memaddress = res_q[7:0];
  assign bus.invalue    = inval_q;
  assign bus.memRead    = mr_q;
  assign bus.memWrite   = mw_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_execute_stage.sv
// Directed and randomized checks of execute_stage against an
// arithmetic reference model of the EX-stage ALU and timing.
module tb_execute_stage;

  logic clock = 1'b0;
  logic reset;
  int tests = 0;
  int fails = 0;

  execute_stage_if bus();

  execute_stage dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

`ifdef EXEC_MULT_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(
    input logic [3:0] op, input logic [31:0] a,
    input logic [31:0] b);
    case (op)
      4'd0:  return a & b;
      4'd1:  return a | b;
      4'd2:  return a + b;
      4'd6:  return a - b;
      4'd7:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd12: return ~(a | b);
      4'd8:  return MUL_EN ? a * b : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic idle_inputs();
    bus.stage = 3'd0;
    bus.aluop = 4'd0;
    bus.operandA = '0;
    bus.operandB = '0;
    bus.immediate = '0;
    bus.aluSrc = 1'b0;
    bus.memRead_in = 1'b0;
    bus.memWrite_in = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [15:0] imm, input logic src,
                        input logic mr, input logic mw,
                        input int hold);
    logic [31:0] bv, e;
    int el, lat, scnt;
    bv = src ? 32'($signed(imm)) : b;
    e  = ref_alu(op, a, bv);
    el = (MUL_EN && op == 4'd8) ? 33 : 1;
    bus.aluop = op;
    bus.operandA = a;
    bus.operandB = b;
    bus.immediate = imm;
    bus.aluSrc = src;
    bus.memRead_in = mr;
    bus.memWrite_in = mw;
    bus.stage = 3'd2;
    #1;
    lat = 0;
    scnt = 0;
    while (!bus.done && lat < 100) begin
      if (bus.stall) scnt++;
      tick();
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(el));
    check({tag, "_stallcnt"}, 32'(scnt), (el > 1) ? 32'(el) : 32'd0);
    check({tag, "_res"}, bus.aluresult, e);
    check({tag, "_zero"}, 32'(bus.zero), 32'(e == 0));
    check({tag, "_addr"}, 32'(bus.memaddress), 32'(e[7:0]));
    check({tag, "_inval"}, bus.invalue, b);
    check({tag, "_mrd"}, 32'(bus.memRead), 32'(mr));
    check({tag, "_mwr"}, 32'(bus.memWrite), 32'(mw));
    check({tag, "_stall0"}, 32'(bus.stall), 32'd0);
    for (int i = 0; i < hold; i++) begin
      bus.operandA = $urandom;
      bus.operandB = $urandom;
      tick();
      check({tag, "_holddone"}, 32'(bus.done), 32'd0);
      check({tag, "_holdres"}, bus.aluresult, e);
    end
    bus.stage = 3'd3;
    bus.operandA = $urandom;
    bus.aluop = 4'($urandom);
    tick();
    check({tag, "_memdone"}, 32'(bus.done), 32'd0);
    check({tag, "_memres"}, bus.aluresult, e);
    check({tag, "_meminval"}, bus.invalue, b);
    check({tag, "_memmwr"}, 32'(bus.memWrite), 32'(mw));
    bus.stage = 3'd0;
    tick();
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_res"}, bus.aluresult, 32'd0);
    check({tag, "_zero"}, 32'(bus.zero), 32'd0);
    check({tag, "_addr"}, 32'(bus.memaddress), 32'd0);
    check({tag, "_inval"}, bus.invalue, 32'd0);
    check({tag, "_mrw"}, 32'({bus.memRead, bus.memWrite}), 32'd0);
    check({tag, "_done"}, 32'(bus.done), 32'd0);
    check({tag, "_stall"}, 32'(bus.stall), 32'd0);
  endtask

  logic [3:0] ops [8];

  initial begin
    ops = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12, 4'd8, 4'd3};
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    bus.stage = 3'd2;
    bus.aluop = 4'd8;
    #1;
    check_cleared("reset");
    bus.stage = 3'd0;
    reset = 1'b0;
    tick();

    run_op("addi", 4'd2, 32'd10, 32'd0, 16'hFFFE, 1'b1, 1'b0, 1'b0, 0);
    run_op("sw", 4'd2, 32'd4, 32'hDEADBEEF, 16'h0, 1'b1, 1'b0, 1'b1, 0);
    run_op("sub", 4'd6, 32'd5, 32'd5, 16'h0, 1'b0, 1'b1, 1'b0, 0);
    run_op("slt", 4'd7, 32'hFFFFFFFF, 32'd1, 16'h0, 1'b0, 1'b0, 1'b0, 0);
    run_op("nor", 4'd12, 32'hF0F0_0000, 32'h0000_0F0F, 16'h0, 1'b0, 1'b0, 1'b0, 0);
    run_op("mul", 4'd8, 32'd7, 32'd6, 16'h0, 1'b0, 1'b0, 1'b0, 0);
    run_op("unk", 4'd3, 32'd9, 32'd9, 16'h0, 1'b0, 1'b1, 1'b1, 0);
    run_op("hold", 4'd2, 32'd100, 32'd23, 16'h0, 1'b0, 1'b0, 1'b0, 2);

    // Abort a multiply partway through.
    bus.aluop = 4'd8;
    bus.operandA = 32'd12345;
    bus.operandB = 32'd678;
    bus.aluSrc = 1'b0;
    bus.memRead_in = 1'b1;
    bus.stage = 3'd2;
    for (int i = 0; i < 10; i++) tick();
    reset = 1'b1;
    tick();
    check_cleared("midreset");
    reset = 1'b0;
    idle_inputs();
    tick();
    check_cleared("postreset");
    run_op("addafter", 4'd2, 32'd40, 32'd2, 16'h0, 1'b0, 1'b0, 1'b0, 0);

    for (int n = 0; n < 40; n++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      run_op("rnd", ops[$urandom_range(0, 7)], a, b,
             16'($urandom), 1'($urandom), 1'($urandom),
             1'($urandom), $urandom_range(0, 1));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
